rom_dl_sequencer: RTL and testbench

//  Sits between data_io and the galaga core on clk_18. Forwards ROM download

---
 rtl/rom_dl_sequencer.sv | 161 ++++++++++++++++
 tb/tb_rom_dl_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_dl_sequencer.sv
// ROM download sequencer between data_io and the galaga core: forwards ROM bytes,
// counts and checksums them, and holds the core in reset until a valid image is in.
module rom_dl_sequencer #(
    parameter logic [7:0]  ROM_INDEX   = 8'd0,
    parameter int unsigned ROM_SIZE    = 32768,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned HOLD_CYCLES = 1024
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic              user_reset,
    output logic [ADDR_W-1:0] dn_addr,
    output logic [7:0]        dn_data,
    output logic              dn_wr,
    output logic              core_reset,
    output logic              dl_done,
    output logic              dl_error,
    output logic [15:0]       checksum,
    output logic [ADDR_W:0]   byte_count
);

    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_WAIT  = 3'd0,
        S_LOAD  = 3'd1,
        S_HOLD  = 3'd2,
        S_RUN   = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                start_q;
    logic                overflow_q;
    logic [HOLD_W-1:0]   hold_cnt_q;

    logic start_c, start_rise_c, other_dl_c, in_range_c;
    logic enter_load_c, accept_c, ovf_set_c, hold_load_c;
    logic finish_ok_c, finish_bad_c, core_reset_d_c;

    assign start_c      = ioctl_download && (ioctl_index == ROM_INDEX);
    assign start_rise_c = start_c && !start_q;
    assign other_dl_c   = ioctl_download && (ioctl_index != ROM_INDEX);
    assign in_range_c   = 32'(ioctl_addr) < ROM_SIZE;

    // State register
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state_q <= S_WAIT;
        else          state_q <= state_d;
    end

    // Next state and per-cycle datapath controls
    always_comb begin
        state_d        = state_q;
        enter_load_c   = 1'b0;
        accept_c       = 1'b0;
        ovf_set_c      = 1'b0;
        hold_load_c    = 1'b0;
        finish_ok_c    = 1'b0;
        finish_bad_c   = 1'b0;
        core_reset_d_c = 1'b1;

        case (state_q)
            S_WAIT, S_RUN, S_FAULT: begin
                if (start_rise_c) begin
                    state_d      = S_LOAD;
                    enter_load_c = 1'b1;
                end
            end
            S_LOAD: begin
                // The strobe in the cycle the download level drops still belongs to this load.
                if (ioctl_wr && (ioctl_index == ROM_INDEX)) begin
                    if (in_range_c) accept_c  = 1'b1;
                    else            ovf_set_c = 1'b1;
                end
                if (!ioctl_download) begin
                    state_d     = S_HOLD;
                    hold_load_c = 1'b1;
                end
            end
            S_HOLD: begin
                if (hold_cnt_q == '0) begin
                    if ((byte_count == CNT_W'(ROM_SIZE)) && !overflow_q) begin
                        state_d     = S_RUN;
                        finish_ok_c = 1'b1;
                    end else begin
                        state_d      = S_FAULT;
                        finish_bad_c = 1'b1;
                    end
                end
            end
            default: state_d = S_WAIT;
        endcase

        if (state_d == S_RUN) core_reset_d_c = user_reset;
        if (other_dl_c)       core_reset_d_c = 1'b1;
    end

    // Start edge detect, hold timer and core reset
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            start_q    <= 1'b0;
            hold_cnt_q <= '0;
            core_reset <= 1'b1;
        end else begin
            start_q    <= start_c;
            core_reset <= core_reset_d_c;
            if (hold_load_c)
                hold_cnt_q <= HOLD_W'(HOLD_CYCLES - 1);
            else if ((state_q == S_HOLD) && (hold_cnt_q != '0))
                hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
        end
    end

    // Forwarding port to the core loader
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dn_wr   <= 1'b0;
            dn_addr <= '0;
            dn_data <= '0;
        end else begin
            dn_wr <= accept_c;
            if (accept_c) begin
                dn_addr <= ioctl_addr[ADDR_W-1:0];
                dn_data <= ioctl_dout;
            end
        end
    end

    // Load statistics and completion status
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            checksum   <= '0;
            byte_count <= '0;
            overflow_q <= 1'b0;
            dl_done    <= 1'b0;
            dl_error   <= 1'b0;
        end else if (enter_load_c) begin
            checksum   <= '0;
            byte_count <= '0;
            overflow_q <= 1'b0;
            dl_done    <= 1'b0;
            dl_error   <= 1'b0;
        end else begin
            if (accept_c) begin
                checksum <= checksum + 16'(ioctl_dout);
                if (byte_count != '1) byte_count <= byte_count + CNT_W'(1);
            end
            if (ovf_set_c)    overflow_q <= 1'b1;
            if (finish_ok_c)  dl_done    <= 1'b1;
            if (finish_bad_c) dl_error   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rom_dl_sequencer.sv
// Randomized scoreboard bench for rom_dl_sequencer, run with a reduced ROM size and hold time.
module tb_rom_dl_sequencer;

    localparam int unsigned ROM_SIZE = 1024;
    localparam int unsigned ADDR_W   = 11;
    localparam int unsigned HOLD     = 16;
    localparam logic [7:0]  ROM_IDX  = 8'd0;
    localparam int          CNT_MAX  = (1 << (ADDR_W + 1)) - 1;

    logic              clk_sys = 1'b0;
    logic              reset_n;
    logic              ioctl_download;
    logic [7:0]        ioctl_index;
    logic              ioctl_wr;
    logic [24:0]       ioctl_addr;
    logic [7:0]        ioctl_dout;
    logic              user_reset;
    logic [ADDR_W-1:0] dn_addr;
    logic [7:0]        dn_data;
    logic              dn_wr;
    logic              core_reset;
    logic              dl_done;
    logic              dl_error;
    logic [15:0]       checksum;
    logic [ADDR_W:0]   byte_count;

    rom_dl_sequencer #(
        .ROM_INDEX(ROM_IDX), .ROM_SIZE(ROM_SIZE), .ADDR_W(ADDR_W), .HOLD_CYCLES(HOLD)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .user_reset(user_reset), .dn_addr(dn_addr),
        .dn_data(dn_data), .dn_wr(dn_wr), .core_reset(core_reset), .dl_done(dl_done),
        .dl_error(dl_error), .checksum(checksum), .byte_count(byte_count)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        int                cyc;
        logic [ADDR_W-1:0] a;
        logic [7:0]        d;
    } exp_t;
    exp_t sb[$];

    // Reference model of the current/last ROM load
    int m_sum, m_cnt;
    bit m_ovf;

    // Monitor: every forwarded write must match the oldest expected write
    always @(negedge clk_sys) begin
        if (reset_n && dn_wr) begin
            if (sb.size() == 0) begin
                chk("dn_wr_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("dn_wr_cycle", cyc, e.cyc);
                chk("dn_addr", dn_addr, e.a);
                chk("dn_data", dn_data, e.d);
            end
        end
    end

    task automatic put_byte(input logic [24:0] a, input logic [7:0] d, input bit fall);
        int gap;
        gap = $urandom_range(0, 2);
        repeat (gap) begin @(posedge clk_sys); #1; ioctl_wr = 1'b0; end
        @(posedge clk_sys); #1;
        ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
        if (fall) ioctl_download = 1'b0;
        if (32'(a) < ROM_SIZE) begin
            sb.push_back('{cyc + 1, ADDR_W'(a), d});
            m_sum = (m_sum + int'(d)) % 65536;
            if (m_cnt < CNT_MAX) m_cnt++;
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    task automatic start_load();
        @(posedge clk_sys); #1;
        ioctl_index = ROM_IDX; ioctl_download = 1'b1; ioctl_wr = 1'b0;
        m_sum = 0; m_cnt = 0; m_ovf = 1'b0;
        @(posedge clk_sys); #1;
    endtask

    // n bytes at sequential addresses (mod ROM_SIZE); optionally one extra byte at bad_addr
    task automatic run_load(input int n, input int bad_at, input logic [24:0] bad_addr,
                            input bit rnd, input bit wr_on_fall, output int fall_cyc);
        int j;
        logic [24:0] a;
        logic [7:0]  d;
        logic [31:0] jv;
        start_load();
        for (int i = 0; i < n; i++) begin
            j  = (bad_at >= 0 && i > bad_at) ? i - 1 : i;
            jv = 32'(j);
            a  = (i == bad_at) ? bad_addr : 25'(j % ROM_SIZE);
            d  = rnd ? 8'($urandom) : jv[7:0];
            put_byte(a, d, wr_on_fall && (i == n - 1));
        end
        if (wr_on_fall) begin
            fall_cyc = cyc;
            @(posedge clk_sys); #1; ioctl_wr = 1'b0;
        end else begin
            @(posedge clk_sys); #1; ioctl_wr = 1'b0; ioctl_download = 1'b0;
            fall_cyc = cyc;
        end
    endtask

    // Reset is released HOLD cycles after the first edge that sees the download low
    task automatic wait_finish(input string tag, input int fall_cyc);
        bit ok;
        int rel;
        ok  = (m_cnt == ROM_SIZE) && !m_ovf;
        rel = -1;
        @(negedge clk_sys); @(negedge clk_sys);
        chk({tag, "_hold_core_reset"}, core_reset, 1);
        chk({tag, "_hold_done_low"}, dl_done, 0);
        for (int k = 0; k < int'(HOLD) + 8; k++) begin
            @(negedge clk_sys);
            if (rel < 0 && core_reset == 1'b0) rel = cyc;
        end
        if (ok) chk({tag, "_release_cycle"}, rel, fall_cyc + 1 + int'(HOLD));
        else    chk({tag, "_fault_core_reset"}, core_reset, 1);
        chk({tag, "_dl_done"}, dl_done, ok);
        chk({tag, "_dl_error"}, dl_error, !ok);
        chk({tag, "_checksum"}, checksum, m_sum);
        chk({tag, "_byte_count"}, byte_count, m_cnt);
        chk({tag, "_all_forwarded"}, sb.size(), 0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_dn_wr"}, dn_wr, 0);
        chk({tag, "_dn_addr"}, dn_addr, 0);
        chk({tag, "_dn_data"}, dn_data, 0);
        chk({tag, "_core_reset"}, core_reset, 1);
        chk({tag, "_dl_done"}, dl_done, 0);
        chk({tag, "_dl_error"}, dl_error, 0);
        chk({tag, "_checksum"}, checksum, 0);
        chk({tag, "_byte_count"}, byte_count, 0);
    endtask

    initial begin
        int  fc;
        bit  prev_exp;
        bit  dl_other;
        logic [15:0] sum_run;

        reset_n = 1'b0; ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_wr = 1'b0;
        ioctl_addr = '0; ioctl_dout = '0; user_reset = 1'b0;
        m_sum = 0; m_cnt = 0; m_ovf = 1'b0;
        #23;
        check_reset_values("por");
        @(posedge clk_sys); #1; reset_n = 1'b1;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys); chk("wait_core_reset", core_reset, 1);

        // Full image, data = addr[7:0]
        run_load(ROM_SIZE, -1, '0, 1'b0, 1'b0, fc);
        wait_finish("full", fc);

        // user_reset in RUN shows up on core_reset one cycle later
        prev_exp = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk_sys); #1;
            user_reset = (c >= 2 && c < 5);
            @(negedge clk_sys);
            chk("user_reset_follow", core_reset, prev_exp);
            prev_exp = user_reset;
        end
        @(posedge clk_sys); #1; user_reset = 1'b0;

        // Strobes without a download are ignored
        sum_run = checksum;
        repeat (4) begin
            @(posedge clk_sys); #1;
            ioctl_wr = 1'b1; ioctl_addr = 25'($urandom_range(0, ROM_SIZE - 1)); ioctl_dout = 8'($urandom);
        end
        @(posedge clk_sys); #1; ioctl_wr = 1'b0;
        @(negedge clk_sys);
        chk("idle_wr_checksum", checksum, sum_run);
        chk("idle_wr_count", byte_count, m_cnt);

        // Foreign-index download while running
        prev_exp = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk_sys); #1;
            dl_other = (c >= 2 && c < 8);
            ioctl_index = 8'd1; ioctl_download = dl_other;
            ioctl_wr = dl_other && ($urandom_range(0, 1) == 1);
            ioctl_addr = 25'($urandom_range(0, ROM_SIZE - 1)); ioctl_dout = 8'($urandom);
            @(negedge clk_sys);
            chk("other_idx_core_reset", core_reset, prev_exp);
            prev_exp = dl_other;
        end
        @(posedge clk_sys); #1; ioctl_wr = 1'b0; ioctl_download = 1'b0; ioctl_index = ROM_IDX;
        @(negedge clk_sys);
        chk("other_idx_checksum", checksum, sum_run);
        chk("other_idx_count", byte_count, m_cnt);
        chk("other_idx_done", dl_done, 1);

        // Truncated image faults, then a full image (last strobe on the fall) recovers
        run_load(ROM_SIZE - 1, -1, '0, 1'b1, 1'b0, fc);
        wait_finish("short", fc);
        run_load(ROM_SIZE, -1, '0, 1'b1, 1'b1, fc);
        wait_finish("recover", fc);

        // Out-of-range bytes are dropped and flag an error
        run_load(ROM_SIZE + 1, 300, 25'(ROM_SIZE), 1'b1, 1'b0, fc);
        wait_finish("oob_edge", fc);
        run_load(ROM_SIZE + 1, 700, 25'h0010000, 1'b1, 1'b0, fc);
        wait_finish("oob_alias", fc);

        // Asynchronous reset in the middle of a load
        start_load();
        for (int i = 0; i <= 100; i++) put_byte(25'(i), 8'($urandom), 1'b0);
        #2; reset_n = 1'b0; sb.delete();
        #1; check_reset_values("midload");
        ioctl_wr = 1'b0; ioctl_download = 1'b0;
        @(posedge clk_sys); #1; reset_n = 1'b1;
        run_load(ROM_SIZE, -1, '0, 1'b1, 1'b0, fc);
        wait_finish("after_rst", fc);

        // Counter saturation with repeated addresses
        run_load(CNT_MAX + 5, -1, '0, 1'b1, 1'b0, fc);
        wait_finish("saturate", fc);

        repeat (4) @(posedge clk_sys);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
